// File: rtl/pos_stream_reader_if.sv
// RAM-side and stream-side bus of pos_stream_reader. The master is the reader;
// the slave is the position RAM together with the downstream force pipeline.
interface pos_stream_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output mem_address, mem_data, mem_wren, out_data, out_valid, out_last,
        input  mem_q, out_ready
    );
    modport slave (
        input  mem_address, mem_data, mem_wren, out_data, out_valid, out_last,
        output mem_q, out_ready
    );
endinterface

// File: rtl/pos_stream_reader.sv
// Burst reader for the 2-cycle-latency position RAM with a credit-limited skid FIFO
// and an idle-time host write mux. Optional XOR checksum port: POS_STREAM_CHECKSUM_EN.
module pos_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_WORDS  = 3072,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    input  logic                  host_wren,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
`ifdef POS_STREAM_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    pos_stream_reader_if.master   bus
);
    localparam int LAT = 2;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]                 rd_addr, addr_nxt;
    logic [NW-1:0]                         nw_clamp, issue_left, xfer_left;
    logic [CW-1:0]                         inflight, count;
    logic [PW-1:0]                         wp, rp;
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_mem;
    logic [LAT:1]                          vld_q;
    logic [LAT:0]                          vld_pipe;
    logic                                  start_ok, issue, fifo_wr, fifo_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign start_ok = (state == IDLE) && start;
    assign nw_clamp = (num_words > NW'(NUM_WORDS)) ? NW'(NUM_WORDS) : num_words;
    assign addr_nxt = (rd_addr == ADDR_WIDTH'(NUM_WORDS - 1)) ? '0 : rd_addr + 1'b1;

    // The credit check ignores a same-cycle pop, so the FIFO can never overflow.
    assign issue    = (state == ISSUE) &&
                      (({1'b0, inflight} + {1'b0, count}) < CW1'(FIFO_DEPTH));
    assign vld_pipe = {vld_q, issue};
    assign fifo_wr  = vld_pipe[LAT];
    assign fifo_rd  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (nw_clamp == '0) ? FINISH : ISSUE;
            ISSUE:   if (issue && issue_left == NW'(1)) state_nxt = DRAIN;
            DRAIN:   if (fifo_rd && xfer_left == NW'(1)) state_nxt = FINISH;
            default: state_nxt = IDLE;
        endcase
    end

    // Host path is gated by rst so the RAM sees no writes and a zero bus while in reset.
    always_comb begin
        busy            = (state != IDLE);
        done            = (state == FINISH);
        bus.mem_wren    = 1'b0;
        bus.mem_address = rd_addr;
        bus.mem_data    = '0;
        if (state == IDLE && !rst) begin
            bus.mem_wren    = host_wren;
            bus.mem_address = host_addr;
            bus.mem_data    = host_data;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rd_addr    <= '0;
            issue_left <= '0;
            xfer_left  <= '0;
        end else if (start_ok) begin
            rd_addr    <= start_addr;
            issue_left <= nw_clamp;
            xfer_left  <= nw_clamp;
        end else begin
            if (issue) begin
                rd_addr    <= addr_nxt;
                issue_left <= issue_left - 1'b1;
            end
            if (fifo_rd) xfer_left <= xfer_left - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            inflight <= '0;
        end else begin
            vld_q <= vld_pipe[LAT-1:0];
            case ({issue, fifo_wr})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            fifo_mem <= '0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
        end else begin
            if (fifo_wr) begin
                fifo_mem[wp] <= bus.mem_q;
                wp           <= ptr_inc(wp);
            end
            if (fifo_rd) rp <= ptr_inc(rp);
            case ({fifo_wr, fifo_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.out_data  = fifo_mem[rp];
    assign bus.out_valid = (count != '0);
    // Driven by the transfer counter so it stays right across an address wrap.
    assign bus.out_last  = bus.out_valid && (xfer_left == NW'(1));

`ifdef POS_STREAM_CHECKSUM_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst)          checksum <= '0;
        else if (start_ok) checksum <= '0;
        else if (fifo_rd)  checksum <= checksum ^ bus.out_data;
    end
`endif

`ifndef SYNTHESIS
    fifo_no_overflow: assert property (@(posedge clock) disable iff (rst)
        !(fifo_wr && !fifo_rd && count == CW'(FIFO_DEPTH)));
`endif
endmodule

// File: tb/tb_pos_stream_reader.sv
// Self-checking bench for pos_stream_reader: behavioural RAM, shadow memory model,
// directed plan scenarios plus randomized bursts with random back-pressure.
module tb_pos_stream_reader;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NB = AW + 1;
    localparam int NW = 3072;

    logic          clock = 1'b0;
    logic          rst;
    logic          start, busy, done, host_wren, out_ready;
    logic [AW-1:0] start_addr, host_addr;
    logic [NB-1:0] num_words;
    logic [DW-1:0] host_data;
`ifdef POS_STREAM_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clock = ~clock;
    always_ff @(posedge clock) cyc <= cyc + 1;

    pos_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pos_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .FIFO_DEPTH(4)) dut (
        .clock(clock), .rst(rst), .start(start), .start_addr(start_addr),
        .num_words(num_words), .busy(busy), .done(done), .host_wren(host_wren),
        .host_addr(host_addr), .host_data(host_data),
`ifdef POS_STREAM_CHECKSUM_EN
        .checksum(checksum),
`endif
        .bus(bus)
    );

    // Position RAM: registered address and registered output.
    logic [DW-1:0] ram    [NW];
    logic [DW-1:0] shadow [NW];
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_q;
    always_ff @(posedge clock) begin
        if (bus.mem_wren) ram[bus.mem_address] <= bus.mem_data;
        ram_addr_q <= bus.mem_address;
        ram_q      <= ram[ram_addr_q];
    end
    assign bus.mem_q     = ram_q;
    assign bus.out_ready = out_ready;

    logic [DW-1:0] got_d[$];
    bit            got_l[$];
    int first_vld, done_at, last_hs, unstable, wren_seen;
    bit busy_c1, done_after, busy_after, timed_out;

    task automatic host_write(input int a, input logic [DW-1:0] d);
        host_wren = 1'b1; host_addr = AW'(a); host_data = d;
        shadow[a] = d;
        @(negedge clock);
        host_wren = 1'b0;
    endtask

    // Drives one burst; cycle 0 is the cycle in which start is sampled.
    task automatic run_burst(input int sa, input int n, input int rmode, input bit poke, input bit restart);
        int k = 0;
        bit stall = 0;
        logic [DW-1:0] held = '0;
        got_d.delete(); got_l.delete();
        first_vld = -1; done_at = -1; last_hs = -1; unstable = 0; wren_seen = 0;
        busy_c1 = 0; timed_out = 0;
        while (done_at < 0 && !timed_out) begin
            start      = (k == 0) || (restart && k == 2);
            start_addr = (k == 0) ? AW'(sa) : AW'(100);
            num_words  = (k == 0) ? NB'(n) : NB'(3);
            host_wren  = poke && (k >= 2) && (k <= 5);
            host_addr  = poke ? AW'(12) : '0;
            host_data  = poke ? 32'hDEAD : '0;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 4 == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (k == 1) busy_c1 = busy;
            if (stall && (!bus.out_valid || bus.out_data !== held)) unstable++;
            if (bus.out_valid && first_vld < 0) first_vld = k;
            if (bus.out_valid && out_ready) begin
                got_d.push_back(bus.out_data);
                got_l.push_back(bus.out_last);
                last_hs = k;
            end
            stall = bus.out_valid && !out_ready;
            held  = bus.out_data;
            if (k > 0 && bus.mem_wren) wren_seen++;
            if (done) done_at = k;
            @(negedge clock);
            k++;
            if (k > 20000) timed_out = 1;
        end
        start = 0; host_wren = 0; host_addr = '0; host_data = '0; out_ready = 0;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clock);
        host_addr = AW'(7); host_data = 32'h99;
        #1;
        total++; if ({busy, done, bus.out_valid, bus.out_last, bus.mem_wren} !== 5'b0) begin
            bad++; $display("FAIL reset ctl: got %b want 00000", {busy, done, bus.out_valid, bus.out_last, bus.mem_wren}); end
        total++; if (bus.out_data !== '0) begin
            bad++; $display("FAIL reset out_data: got %h want 0", bus.out_data); end
        total++; if (bus.mem_address !== '0 || bus.mem_data !== '0) begin
            bad++; $display("FAIL reset mem bus: got %h/%h want 0/0", bus.mem_address, bus.mem_data); end
`ifdef POS_STREAM_CHECKSUM_EN
        total++; if (checksum !== '0) begin
            bad++; $display("FAIL reset checksum: got %h want 0", checksum); end
`endif
        @(negedge clock);
        rst = 1'b0; host_addr = '0; host_data = '0;
        @(negedge clock);
    endtask

    task automatic preload();
        for (int i = 0; i < NW; i++) host_write(i, DW'(i));
    endtask

    task automatic test_basic();
        int sa = 10, n = 5;
        run_burst(sa, n, 0, 0, 0);
        total++; if (timed_out) begin bad++; $display("FAIL basic timeout: got 1 want 0"); end
        total++; if (got_d.size() != n) begin
            bad++; $display("FAIL basic count: got %0d want %0d", got_d.size(), n); end
        for (int i = 0; i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== shadow[(sa + i) % NW] || got_l[i] !== (i == n - 1)) begin
                bad++; $display("FAIL basic word %0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], shadow[(sa + i) % NW], i == n - 1); end
        end
        total++; if (first_vld != 4) begin
            bad++; $display("FAIL basic first valid: got %0d want 4", first_vld); end
        total++; if (last_hs != first_vld + n - 1) begin
            bad++; $display("FAIL basic throughput: got last %0d want %0d", last_hs, first_vld + n - 1); end
        total++; if (done_at != last_hs + 1) begin
            bad++; $display("FAIL basic done: got %0d want %0d", done_at, last_hs + 1); end
        total++; if ({busy_c1, done_after, busy_after} !== 3'b100) begin
            bad++; $display("FAIL basic busy/done pulse: got %b want 100", {busy_c1, done_after, busy_after}); end
`ifdef POS_STREAM_CHECKSUM_EN
        total++; if (checksum !== 32'h0000000E) begin
            bad++; $display("FAIL basic checksum: got %h want 0000000e", checksum); end
`endif
    endtask

    task automatic test_wrap();
        int sa = 3070, n = 4;
        run_burst(sa, n, 0, 0, 0);
        total++; if (got_d.size() != n || timed_out) begin
            bad++; $display("FAIL wrap count: got %0d want %0d", got_d.size(), n); end
        for (int i = 0; i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== shadow[(sa + i) % NW] || got_l[i] !== (i == n - 1)) begin
                bad++; $display("FAIL wrap word %0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], shadow[(sa + i) % NW], i == n - 1); end
        end
    endtask

    task automatic test_backpressure();
        int sa = 200, n = 20;
        run_burst(sa, n, 1, 0, 0);
        total++; if (got_d.size() != n || timed_out) begin
            bad++; $display("FAIL backpressure count: got %0d want %0d", got_d.size(), n); end
        for (int i = 0; i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== shadow[(sa + i) % NW] || got_l[i] !== (i == n - 1)) begin
                bad++; $display("FAIL backpressure word %0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], shadow[(sa + i) % NW], i == n - 1); end
        end
        total++; if (unstable != 0) begin
            bad++; $display("FAIL backpressure stall stability: got %0d changes want 0", unstable); end
        total++; if (done_at != last_hs + 1) begin
            bad++; $display("FAIL backpressure done: got %0d want %0d", done_at, last_hs + 1); end
    endtask

    task automatic test_edge_lengths();
        int sa = 500;
        run_burst(100, 0, 0, 0, 0);
        total++; if (got_d.size() != 0 || first_vld != -1) begin
            bad++; $display("FAIL empty burst valid: got %0d words want 0", got_d.size()); end
        total++; if (done_at != 1 || done_after !== 1'b0) begin
            bad++; $display("FAIL empty burst done: got cycle %0d want 1", done_at); end
        run_burst(sa, 4000, 0, 0, 0);
        total++; if (got_d.size() != NW || timed_out) begin
            bad++; $display("FAIL clamp count: got %0d want %0d", got_d.size(), NW); end
        for (int i = 0; i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== shadow[(sa + i) % NW] || got_l[i] !== (i == NW - 1)) begin
                bad++; $display("FAIL clamp word %0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], shadow[(sa + i) % NW], i == NW - 1); end
        end
    endtask

    task automatic test_host_isolation();
        int sa = 40, n = 6;
        run_burst(sa, n, 0, 1, 1);
        total++; if (wren_seen != 0) begin
            bad++; $display("FAIL isolation mem_wren: got %0d cycles want 0", wren_seen); end
        total++; if (got_d.size() != n || timed_out) begin
            bad++; $display("FAIL restart ignored count: got %0d want %0d", got_d.size(), n); end
        for (int i = 0; i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== shadow[(sa + i) % NW] || got_l[i] !== (i == n - 1)) begin
                bad++; $display("FAIL restart ignored word %0d: got %h want %h", i, got_d[i], shadow[(sa + i) % NW]); end
        end
        total++; if (ram[12] !== shadow[12]) begin
            bad++; $display("FAIL isolation ram[12]: got %h want %h", ram[12], shadow[12]); end
        run_burst(12, 1, 0, 0, 0);
        total++; if (got_d.size() != 1 || got_d[0] !== shadow[12]) begin
            bad++; $display("FAIL isolation reread 12: got %0d words want 1 of %h", got_d.size(), shadow[12]); end
    endtask

    task automatic test_reset_mid_burst();
        int hs = 0, k = 0;
        start = 1; start_addr = AW'(20); num_words = NB'(10); out_ready = 1;
        while (hs < 3 && k < 200) begin
            if (bus.out_valid && out_ready) hs++;
            @(negedge clock);
            start = 0;
            k++;
        end
        total++; if (hs != 3) begin bad++; $display("FAIL midreset handshakes: got %0d want 3", hs); end
        rst = 1'b1; host_addr = AW'(5); host_data = 32'h77;
        #1;
        total++; if ({busy, done, bus.out_valid, bus.out_last, bus.mem_wren} !== 5'b0) begin
            bad++; $display("FAIL midreset ctl: got %b want 00000", {busy, done, bus.out_valid, bus.out_last, bus.mem_wren}); end
        total++; if (bus.out_data !== '0 || bus.mem_address !== '0 || bus.mem_data !== '0) begin
            bad++; $display("FAIL midreset data: got %h/%h/%h want 0/0/0", bus.out_data, bus.mem_address, bus.mem_data); end
        @(negedge clock);
        rst = 1'b0; host_addr = '0; host_data = '0; out_ready = 0;
        @(negedge clock);
        total++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL midreset idle: got busy %b valid %b want 0 0", busy, bus.out_valid); end
        run_burst(0, 2, 0, 0, 0);
        total++; if (got_d.size() != 2 || timed_out) begin
            bad++; $display("FAIL post-reset count: got %0d want 2", got_d.size()); end
        for (int i = 0; i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== shadow[i] || got_l[i] !== (i == 1)) begin
                bad++; $display("FAIL post-reset word %0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], shadow[i], i == 1); end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int sa = $urandom_range(0, NW - 1);
            int n  = $urandom_range(1, 40);
            for (int w = 0; w < 3; w++) host_write($urandom_range(0, NW - 1), $urandom);
            host_write((sa + 1) % NW, $urandom);
            run_burst(sa, n, 2, 0, 0);
            total++; if (got_d.size() != n || timed_out) begin
                bad++; $display("FAIL random %0d count: got %0d want %0d", t, got_d.size(), n); end
            for (int i = 0; i < got_d.size(); i++) begin
                total++;
                if (got_d[i] !== shadow[(sa + i) % NW] || got_l[i] !== (i == n - 1)) begin
                    bad++; $display("FAIL random %0d word %0d: got %h/%b want %h/%b", t, i, got_d[i], got_l[i], shadow[(sa + i) % NW], i == n - 1); end
            end
            total++; if (unstable != 0 || done_at != last_hs + 1) begin
                bad++; $display("FAIL random %0d stall/done: got %0d changes, done %0d want 0, %0d", t, unstable, done_at, last_hs + 1); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 0; start_addr = '0; num_words = '0;
        host_wren = 0; host_addr = '0; host_data = '0; out_ready = 0;
        test_reset();
        preload();
        test_basic();
        test_wrap();
        test_backpressure();
        test_edge_lengths();
        test_host_isolation();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pos_stream_reader.md
Name: pos_stream_reader

Overview:
- Read controller that sits directly in front of the 3072x32 single-port position RAM (registered address and registered output, 2-cycle read latency).
- Walks a contiguous particle range, issuing one read per cycle, and presents the words as a valid/ready stream to the downstream force pipeline.
- Absorbs downstream back-pressure with a credit-limited skid FIFO.
- While idle, muxes a host write port onto the RAM so position memory can be reloaded between timesteps.

Parameters:
- DATA_WIDTH, 32, position word width.
- ADDR_WIDTH, 12, RAM address width.
- NUM_WORDS, 3072, RAM depth; addresses wrap modulo this value.
- FIFO_DEPTH, 4, skid FIFO entries; must be at least read latency + 2.

Ports:
- clock  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a burst; sampled only in IDLE.
- start_addr  in  ADDR_WIDTH  first word address; must be less than NUM_WORDS.
- num_words  in  ADDR_WIDTH+1  burst length; 0 = empty burst; values above NUM_WORDS clamp to NUM_WORDS.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at burst completion.
- host_wren  in  1  host write strobe; honoured only in IDLE.
- host_addr  in  ADDR_WIDTH  host write address.
- host_data  in  DATA_WIDTH  host write data.
- mem_address  out  ADDR_WIDTH  to RAM address.
- mem_data  out  DATA_WIDTH  to RAM data.
- mem_wren  out  1  to RAM write enable.
- mem_q  in  DATA_WIDTH  RAM read data, valid 2 cycles after the address is presented.
- out_data  out  DATA_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  high with the final word of the burst.

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_wren=0, mem_address=0, mem_data=0. FIFO is empty, credits are full, FSM is in IDLE. Reset asserted mid-burst discards all in-flight reads and queued words; the first cycle after reset is IDLE.
- FSM states:
  - IDLE: goes to ISSUE on start with clamped num_words > 0. Goes to FINISH on start with num_words = 0.
  - ISSUE: goes to DRAIN after the last read is issued.
  - DRAIN: goes to FINISH when the last word is handshaked.
  - FINISH: pulses done for one cycle, then returns to IDLE.
- A start asserted while not in IDLE is ignored.
- Issue rule: a read is issued in a cycle only if the in-flight count plus FIFO occupancy is less than FIFO_DEPTH. Each issued read increments the in-flight count. The in-flight count decrements 2 cycles later, when mem_q is written into the FIFO.
- Address generation: the next address is the current address + 1; it becomes 0 when the current address is NUM_WORDS-1 (wrap, not a power-of-2 mask).
- Mux: mem_wren equals host_wren only in IDLE; otherwise it is 0. In IDLE, mem_address/mem_data follow host_addr/host_data. Outside IDLE, mem_address is the read address.
- Stream: out_data/out_valid come from the FIFO head. out_valid stays high and out_data stays stable until out_ready is seen. A word is transferred on out_valid & out_ready.
- out_last is computed from a transfer counter, not from the address, so it stays correct across wrap.
- Latency with out_ready held high: start sampled at cycle 0, first address at cycle 1, mem_q at cycle 3, out_valid at cycle 4. Sustained throughput is 1 word per cycle. done pulses 1 cycle after the last handshake.
- A FIFO write and a FIFO read in the same cycle are both honoured; occupancy is unchanged.
- The FIFO can never overflow by construction. An overflow attempt is a design error and must be flagged by an assertion in simulation.

Optional Feature:
- Macro: POS_STREAM_CHECKSUM_EN.
- Enabled:
  - Adds an output port checksum[DATA_WIDTH-1:0], reset to 0.
  - checksum clears when start is accepted.
  - It accumulates the XOR of every handshaked out_data word.
  - It is stable from the done pulse until the next accepted start.
- Disabled: the port and logic are absent. All other behaviour is identical.

Test Plan:
- RAM preloaded with word[i] = i via the host port in IDLE; start_addr=10, num_words=5, out_ready=1 -> data 10..14 out on consecutive cycles; first out_valid 4 cycles after start; out_last with 14; done 1 cycle later.
- Wrap: start_addr=3070, num_words=4 -> data 3070, 3071, 0, 1; out_last on 1.
- Back-pressure: num_words=20 with out_ready toggling 3 low / 1 high -> all 20 words in order, none lost or duplicated, FIFO occupancy never exceeds 4, out_data stable while stalled.
- Edge lengths: num_words=0 -> done pulses with no out_valid. num_words=4000 -> clamps to 3072 words.
- Host isolation: host_wren asserted mid-burst with addr=12, data=0xDEAD -> mem_wren stays 0 and location 12 is unchanged. start asserted while busy -> ignored.
- Reset mid-burst after 3 words are handshaked -> all outputs return to reset values. A new start with start_addr=0, num_words=2 then yields 0, 1. With POS_STREAM_CHECKSUM_EN, the 10..14 burst gives checksum 0x0000000E.
